// File: rtl/mips32_pkg.sv
// MIPS32 opcode constants, instruction-class encodings and shared decode helpers.
package mips32_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      ITYPE_R = 2'd0,
      ITYPE_I = 2'd1,
      ITYPE_J = 2'd2
   } itype_e;

   function automatic itype_e decode_itype(input logic [5:0] op);
      if (op == OP_RTYPE) begin
         return ITYPE_R;
      end else if (op == OP_J || op == OP_JAL) begin
         return ITYPE_J;
      end
      return ITYPE_I;
   endfunction

   // Logical immediates zero-extend, lui shifts up, everything else sign-extends.
   function automatic logic [31:0] extend_imm(input logic [5:0] op, input logic [15:0] imm);
      case (op)
         OP_ANDI, OP_ORI, OP_XORI: return {16'h0000, imm};
         OP_LUI:                   return {imm, 16'h0000};
         default:                  return {{16{imm[15]}}, imm};
      endcase
   endfunction

endpackage

// File: rtl/ir_queue.sv
// DEPTH-entry circular FIFO of instruction words with push, pop, flush and occupancy status.
module ir_queue #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [31:0]      wdata,
   input  logic             pop,
   input  logic             flush,
   output logic [31:0]      rdata,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0]      mem [DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign count   = count_q;
   assign rdata   = mem[head_q];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) tail_q <= next_ptr(tail_q);
         if (do_pop)  head_q <= next_ptr(head_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; only entries between head and tail are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[tail_q] <= wdata;
   end

endmodule

// File: rtl/instr_queue_reg.sv
// Queued MIPS32 instruction register with field decode; define IR_BYPASS_EN to let an
// empty queue forward in_data straight into IR on ir_w.
module instr_queue_reg
   import mips32_pkg::*;
#(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_IR = MIPS_NOP
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic [31:0]                  in_data,
   output logic                         in_ready,
   input  logic                         ir_w,
   input  logic                         flush,
   output logic [31:0]                  ir,
   output logic                         ir_valid,
   output logic [5:0]                   opcode,
   output logic [4:0]                   rs,
   output logic [4:0]                   rt,
   output logic [4:0]                   rd,
   output logic [4:0]                   shamt,
   output logic [5:0]                   funct,
   output logic [15:0]                  imm16,
   output logic [31:0]                  imm_ext,
   output logic [25:0]                  jaddr,
   output logic [1:0]                   itype,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   logic [31:0] ir_q;
   logic        ir_valid_q;
   logic [31:0] head_data;
   logic        bypass;
   logic        q_push, q_pop;

`ifdef IR_BYPASS_EN
   assign bypass = empty && in_valid && ir_w && !flush;
`else
   assign bypass = 1'b0;
`endif

   assign in_ready = !full;
   assign q_push   = in_valid && in_ready && !bypass;
   assign q_pop    = ir_w;

   ir_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (q_push),
      .wdata (in_data),
      .pop   (q_pop),
      .flush (flush),
      .rdata (head_data),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q       <= RESET_IR;
         ir_valid_q <= 1'b0;
      end else if (flush) begin
         ir_q       <= RESET_IR;
         ir_valid_q <= 1'b0;
      end else if (ir_w) begin
         if (bypass) begin
            ir_q       <= in_data;
            ir_valid_q <= 1'b1;
         end else if (!empty) begin
            ir_q       <= head_data;
            ir_valid_q <= 1'b1;
         end else begin
            // Popping an empty queue inserts a bubble rather than stalling.
            ir_q       <= RESET_IR;
            ir_valid_q <= 1'b0;
         end
      end
   end

   assign ir       = ir_q;
   assign ir_valid = ir_valid_q;
   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign shamt    = ir_q[10:6];
   assign funct    = ir_q[5:0];
   assign imm16    = ir_q[15:0];
   assign jaddr    = ir_q[25:0];
   assign itype    = decode_itype(ir_q[31:26]);
   assign imm_ext  = extend_imm(ir_q[31:26], ir_q[15:0]);

endmodule

// File: tb/tb_instr_queue_reg.sv
// Scoreboard bench for instr_queue_reg: expected IR loads are queued by the stimulus and
// checked by an independent monitor on every edge that loads IR.
module tb_instr_queue_reg;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          clk, rst_n;
   logic          in_valid, in_ready, ir_w, flush;
   logic [31:0]   in_data, ir, imm_ext;
   logic          ir_valid, empty, full;
   logic [5:0]    opcode, funct;
   logic [4:0]    rs, rt, rd, shamt;
   logic [15:0]   imm16;
   logic [25:0]   jaddr;
   logic [1:0]    itype;
   logic [CW-1:0] count;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0]   ir;
      logic          v;
      logic [CW-1:0] cnt;
      logic [1:0]    it;
      logic [31:0]   imm;
   } exp_t;

   exp_t exp_q[$];

   logic [5:0] ops [6] = '{6'h00, 6'h08, 6'h0C, 6'h0F, 6'h02, 6'h23};

   instr_queue_reg #(
      .DEPTH    (DEPTH),
      .RESET_IR (32'h0000_0000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .ir_w     (ir_w),
      .flush    (flush),
      .ir       (ir),
      .ir_valid (ir_valid),
      .opcode   (opcode),
      .rs       (rs),
      .rt       (rt),
      .rd       (rd),
      .shamt    (shamt),
      .funct    (funct),
      .imm16    (imm16),
      .imm_ext  (imm_ext),
      .jaddr    (jaddr),
      .itype    (itype),
      .count    (count),
      .empty    (empty),
      .full     (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] ref_itype(input logic [31:0] w);
      if (w[31:26] == 6'h00) return 2'd0;
      if (w[31:26] == 6'h02 || w[31:26] == 6'h03) return 2'd2;
      return 2'd1;
   endfunction

   function automatic logic [31:0] ref_imm(input logic [31:0] w);
      if (w[31:26] == 6'h0C || w[31:26] == 6'h0D || w[31:26] == 6'h0E) return {16'h0, w[15:0]};
      if (w[31:26] == 6'h0F) return {w[15:0], 16'h0};
      return {{16{w[15]}}, w[15:0]};
   endfunction

   function automatic logic [31:0] stream_word(input int i);
      return {ops[i % 6], 26'(i * 32'h0041_0203)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic expect_ir(input logic [31:0] w, input logic v, input logic [CW-1:0] c,
                            input logic [1:0] it, input logic [31:0] imm);
      exp_t e;
      e.ir = w; e.v = v; e.cnt = c; e.it = it; e.imm = imm;
      exp_q.push_back(e);
   endtask

   task automatic expect_word(input logic [31:0] w, input logic [CW-1:0] c);
      expect_ir(w, 1'b1, c, ref_itype(w), ref_imm(w));
   endtask

   task automatic expect_bubble(input logic [CW-1:0] c);
      expect_ir(32'h0, 1'b0, c, 2'd0, 32'h0);
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic w, input logic f);
      in_valid = v; in_data = d; ir_w = w; flush = f;
      @(posedge clk);
      #1;
      in_valid = 1'b0; ir_w = 1'b0; flush = 1'b0;
   endtask

   // Monitor: every edge with ir_w or flush out of reset consumes one expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         if (rst_n && (ir_w || flush)) begin
            #2;
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_load: got ir %h, required no load", ir);
            end else begin
               e = exp_q.pop_front();
               check("ir", ir, e.ir);
               check("ir_valid", 32'(ir_valid), 32'(e.v));
               check("count", 32'(count), 32'(e.cnt));
               check("itype", 32'(itype), 32'(e.it));
               check("imm_ext", imm_ext, e.imm);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; ir_w = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_ir", ir, 32'h0);
      check("rst_ir_valid", 32'(ir_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);

      // Fill, then a push that must be refused while full.
      step(1'b1, 32'h2008_0005, 1'b0, 1'b0);
      step(1'b1, 32'h0109_5020, 1'b0, 1'b0);
      check("full_full", 32'(full), 32'd1);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_count", 32'(count), 32'd2);
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      expect_ir(32'h2008_0005, 1'b1, CW'(1), 2'd1, 32'h0000_0005);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("pop_rt", 32'(rt), 32'd8);
      expect_ir(32'h0109_5020, 1'b1, CW'(0), 2'd0, 32'h0000_5020);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      expect_bubble(CW'(0));
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Immediate extension: lui, ori, negative addi.
      step(1'b1, 32'h3C01_8000, 1'b0, 1'b0);
      step(1'b1, 32'h3421_FFFF, 1'b0, 1'b0);
      expect_ir(32'h3C01_8000, 1'b1, CW'(1), 2'd1, 32'h8000_0000);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      expect_ir(32'h3421_FFFF, 1'b1, CW'(0), 2'd1, 32'h0000_FFFF);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 32'h2108_FFFF, 1'b0, 1'b0);
      expect_ir(32'h2108_FFFF, 1'b1, CW'(0), 2'd1, 32'hFFFF_FFFF);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Flush beats a same-edge push and pop; the pushed word must be gone.
      step(1'b1, 32'h1111_1111, 1'b0, 1'b0);
      expect_bubble(CW'(0));
      step(1'b1, 32'h2222_2222, 1'b1, 1'b1);
      check("flush_empty", 32'(empty), 32'd1);
      expect_bubble(CW'(0));
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Push and pop together on an empty queue.
`ifdef IR_BYPASS_EN
      expect_ir(32'h0800_0010, 1'b1, CW'(0), 2'd2, 32'h0000_0010);
      step(1'b1, 32'h0800_0010, 1'b1, 1'b0);
      check("bypass_jaddr", 32'(jaddr), 32'h10);
`else
      expect_bubble(CW'(1));
      step(1'b1, 32'h0800_0010, 1'b1, 1'b0);
      expect_ir(32'h0800_0010, 1'b1, CW'(0), 2'd2, 32'h0000_0010);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("nobypass_jaddr", 32'(jaddr), 32'h10);
`endif

      // Streaming push+pop across pointer wrap.
      step(1'b1, stream_word(0), 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         expect_word(stream_word(i - 1), CW'(1));
         step(1'b1, stream_word(i), 1'b1, 1'b0);
      end
      expect_word(stream_word(20), CW'(0));
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset landing between edges while a pop is pending.
      step(1'b1, 32'h2409_0001, 1'b0, 1'b0);
      step(1'b1, 32'h240A_0002, 1'b0, 1'b0);
      expect_word(32'h2409_0001, CW'(1));
      step(1'b0, 32'h0, 1'b1, 1'b0);
      in_valid = 1'b1; in_data = 32'h240B_0003; ir_w = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      check("arst_ir", ir, 32'h0);
      check("arst_ir_valid", 32'(ir_valid), 32'd0);
      check("arst_count", 32'(count), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; ir_w = 1'b0; rst_n = 1'b1;
      check("arst_hold_empty", 32'(empty), 32'd1);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
